ula_seq_divider: RTL
====================

// Module: ula_seq_divider
// PURPOSE
//  Sequential restoring divider; the inverse companion of the ULA multiply path.
//  Computes an unsigned quotient and remainder, one quotient bit per clock.
//  Sits beside the ULA on the same A_in/B_in operand buses and uses a start/done handshake.
//  The result is registered and held until the next accepted start.
// PARAMETERS
//  N   8   operand width (dividend, divisor, quotient and remainder); N >= 2
// PORTS
//  Tclk      in   1  single clock; all state changes on rising edge
//  Tclr      in   1  reset: synchronous, active-high (sampled on rising Tclk)
//  en        in   1  clock enable; 0 freezes FSM, counter, datapath (outputs hold)
//  start     in   1  request; sampled only in IDLE with en=1
//  A_in      in   N  dividend, captured on accepted start
//  B_in      in   N  divisor, captured on accepted start
//  Q         out  N  quotient, registered
//  R         out  N  remainder, registered
//  busy      out  1  1 in RUN and DONE
//  done      out  1  1 for exactly one en-cycle in DONE; Q/R valid from then on
//  div_zero  out  1  1 with result when the captured divisor was 0; held with Q/R
// BEHAVIOUR
//  Reset: state=IDLE; Q, R, busy, done, div_zero = 0; internal regs cleared. Tclr wins over en.
//  FSM (advances only on edges with en=1):
//   IDLE: start=1 and B_in!=0 -> RUN; dividend/divisor latched; rem=0; cnt=N.
//         start=1 and B_in==0 -> DONE; Q={N{1}}, R=A_in, div_zero=1.
//         start=0 -> stay.
//   RUN:  per edge: rem' = {rem[N-1:0], dvd[N-1]}; dvd <<= 1.
//         If rem' >= divisor: rem = rem' - divisor, q bit = 1; else rem = rem', q bit = 0.
//         cnt-- ; when cnt reaches 0 -> DONE; Q, R loaded; div_zero=0.
//   DONE: done=1 for this cycle; next en edge -> IDLE.
//  Width rules: partial remainder is N+1 bits (no overflow on shift); compare/subtract at N+1.
//   Counter width $clog2(N+1). R < divisor always; A == Q*B + R for B != 0.
//  Latency (en held 1): start accepted at edge 0; done high in the cycle after edge N.
//   Divide-by-zero: done high in the cycle after edge 0.
//  start in RUN/DONE is ignored (no queueing); operand changes after capture have no effect.
//  en=0 mid-RUN stretches latency by exactly the number of low cycles; the result is unchanged.
//  en=0 during DONE keeps done=1 until the next en=1 edge.
//  Tclr mid-RUN aborts: IDLE, all outputs 0 on the following cycle; no done pulse.
//  Q/R/div_zero are not cleared on IDLE entry; they change only on reset or a new result.
// STRUCTURE
//  Shared package (ula_pkg): FSM state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit localparams)
//   and the default width constant N_DEF=8, shared with the ULA.
//  One sub-module: ula_div_step, a combinational single-bit restoring step.
//   Inputs: rem, dvd_msb, divisor. Outputs: rem_next, q_bit.
//  Top level holds the FSM, counter, shift registers and output registers.
// TESTING
//  1 A=55,B=10,start 1 cycle -> done in cycle after edge 8; Q=5,R=5,div_zero=0, busy 9 cycles.
//  2 A=100,B=254 -> Q=0,R=100; A=255,B=1 -> Q=255,R=0; A=254,B=255 -> Q=0,R=254.
//  3 A=90,B=0 -> done in cycle after edge 0; Q=255,R=90,div_zero=1; next valid op clears div_zero.
//  4 A=251,B=50 with en=0 for 3 cycles mid-RUN -> done 3 cycles late; Q=5,R=1.
//  5 start A=10,B=89, then start again with A=200,B=3 during RUN -> ignored; Q=0,R=10; Q/R held in IDLE.
//  6 Tclr at cycle 4 of RUN -> busy=done=Q=R=0 next cycle, no done pulse; new start then runs normally.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath and its sequential divider.
// Contents:
//   N_DEF        default operand width shared with the ULA
//   div_state_e  2-bit divider FSM encoding (ST_IDLE / ST_RUN / ST_DONE)
package ula_pkg;

    localparam int unsigned N_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ula_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem       in   N  current partial remainder (always < divisor)
//   dvd_msb   in   1  next dividend bit shifted into the remainder
//   divisor   in   N  divisor
//   rem_next  out  N  partial remainder after the trial subtraction
//   q_bit     out  1  quotient bit produced by this step
module ula_div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] rem,
    input  logic         dvd_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    // The shifted remainder needs N+1 bits; either branch of the restore fits back in N
    // because the previous remainder was already below the divisor.
    logic [N:0] shifted;
    logic [N:0] diff;

    assign shifted  = {rem, dvd_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/ula_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per enabled clock.
// Ports:
//   Tclk      in   1  clock, rising edge
//   Tclr      in   1  synchronous active-high reset, dominates en
//   en        in   1  clock enable; low freezes all state
//   start     in   1  request, accepted only in ST_IDLE
//   A_in      in   N  dividend
//   B_in      in   N  divisor
//   Q         out  N  quotient (held until next result)
//   R         out  N  remainder (held until next result)
//   busy      out  1  high in ST_RUN and ST_DONE
//   done      out  1  high while in ST_DONE
//   div_zero  out  1  result came from a zero divisor
module ula_seq_divider
    import ula_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         Tclk,
    input  logic         Tclr,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] A_in,
    input  logic [N-1:0] B_in,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int unsigned CntW = $clog2(N + 1);

    div_state_e    state_q;
    logic [N-1:0]  dvd_q;   // dividend shifts out of the top, quotient bits shift in below
    logic [N-1:0]  dvs_q;
    logic [N-1:0]  rem_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;

    logic [N-1:0]  rem_next;
    logic          q_bit;

    ula_div_step #(
        .N(N)
    ) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[N-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge Tclk) begin
        if (Tclr) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (B_in != '0) begin
                            dvd_q   <= A_in;
                            dvs_q   <= B_in;
                            rem_q   <= '0;
                            cnt_q   <= CntW'(N);
                            state_q <= ST_RUN;
                        end else begin
                            q_q     <= '1;
                            r_q     <= A_in;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[N-2:0], q_bit};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        q_q     <= {dvd_q[N-2:0], q_bit};
                        r_q     <= rem_next;
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
